mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer for the shared single-port 8-bit memory (registered read: mem samples rw/addr/data on posedge clk; q updates on the same edge).
Port 0 serves the CPU control unit (fetch and MOVE mem accesses). Port 1 serves a loader/DMA engine.
Serialises accesses, drives the memory interface from registers, and returns read data with a valid pulse to the winning requester.

Parameters:
ADDR_WIDTH, 16, address width of requesters and memory
DATA_WIDTH, 8, data width
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req0  in  1  port 0 access request
rw0  in  1  port 0 direction (1 = write, 0 = read)
addr0  in  ADDR_WIDTH  port 0 address
wdata0  in  DATA_WIDTH  port 0 write data
gnt0  out  1  port 0 request accepted (1-cycle pulse)
rvalid0  out  1  port 0 read data valid (1-cycle pulse)
rdata0  out  DATA_WIDTH  port 0 read data
req1, rw1, addr1, wdata1, gnt1, rvalid1, rdata1  same as port 0, for port 1
mem_rw  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_data  out  DATA_WIDTH  memory write data
mem_q  in  DATA_WIDTH  memory read data

Behaviour:
- All outputs are registered. Reset values: gnt*=0, rvalid*=0, rdata*=0, mem_rw=0, mem_addr=0, mem_data=0. Internal reset values: state=IDLE, last_grant=1 (port 0 wins the first tie).
- States: IDLE, BUSY, RETURN.
- IDLE: arbitration happens only in this state. On an edge where any req is high:
  - Pick the winner.
  - Register mem_addr/mem_data from the winner; mem_rw=rw of the winner.
  - Pulse gnt of the winner; set owner = winner; last_grant = winner.
  - Go to BUSY.
  - If no req is high, stay in IDLE with mem_rw=0.
- Winner selection:
  - One request high: that port.
  - Both high with FIXED_PRIO=0: the port != last_grant.
  - Both high with FIXED_PRIO=1: port 0.
- BUSY: the memory performs the access on this cycle's closing edge. At that edge: mem_rw <= 0, gnt <= 0. Next state is RETURN for a read, IDLE for a write.
- RETURN: at the edge, rdata_owner <= mem_q and rvalid_owner <= 1 for one cycle. The other port's rdata holds its value. Go to IDLE.
- Latency, counted from the request-sampling edge E0:
  - gnt is high in the cycle after E0.
  - Write lands at E1.
  - Read: rvalid/rdata are high in the cycle after E2.
- Throughput: a held req yields 1 write per 2 cycles or 1 read per 3 cycles.
- Requester rules:
  - Hold req, rw, addr and wdata stable until gnt is seen.
  - A req still high in IDLE after gnt is treated as a new access.
  - Deasserting req before gnt withdraws the request; no access occurs.
- mem_addr and mem_data hold their last value when idle. mem_rw is high only during the BUSY cycle of a write, so no spurious writes occur.
- Address is passed through unmodified. Upper-bit truncation is the memory's concern.
- Reset mid-operation:
  - Any state returns to IDLE next cycle.
  - A read in flight is dropped: no rvalid.
  - A write whose BUSY cycle coincides with the rst edge still lands, because memory samples the pre-reset mem_rw=1.
  - last_grant returns to 1.
- req/rw/addr/wdata are ignored while rst is high.

Test Plan:
- Read: mem[0x0010]=0xA5; req0=1, rw0=0, addr0=0x0010 at E0 -> gnt0 is high for one cycle after E0 with mem_addr=0x0010 and mem_rw=0; rvalid0=1 with rdata0=0xA5 in the cycle after E2; rvalid1 stays 0.
- Write/readback: port 1 writes 0x3C to 0x00FF -> mem_rw=1 for exactly one cycle; a following port-1 read of 0x00FF returns rdata1=0x3C; rdata0 is unchanged.
- Round-robin (FIXED_PRIO=0): req0 and req1 held high with reads -> grant order is 0,1,0,1, with gnt pulses 3 cycles apart.
- Fixed priority (FIXED_PRIO=1): both held high -> only gnt0 pulses; after req0 drops, gnt1 pulses on the next IDLE edge.
- Reset during RETURN of a port 0 read -> no rvalid0; all outputs are at reset values the next cycle; the first request after reset is served normally.
- Reset coincident with a write's BUSY edge -> memory holds the written byte; mem_rw=0 afterwards; no gnt or rvalid pulses while rst is high.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter and sequencer for a shared single-port memory with registered read.
// Serialises accesses, drives the memory from registers and returns read data to the owner.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  rw0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  rw1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    RETURN = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   owner;
  logic   win_c;

  // Winner among the active requests; a tie goes to the port that did not win last
  always_comb begin
    win_c = 1'b0;
    if (req0 && req1) begin
      win_c = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    end else begin
      win_c = req1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      mem_rw  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner      <= win_c;
            last_grant <= win_c;
            mem_rw     <= win_c ? rw1 : rw0;
            mem_addr   <= win_c ? addr1 : addr0;
            mem_data   <= win_c ? wdata1 : wdata0;
            gnt0       <= ~win_c;
            gnt1       <= win_c;
            state      <= BUSY;
          end
        end
        // mem_rw still holds the direction of the access being performed
        BUSY: state <= mem_rw ? IDLE : RETURN;
        RETURN: begin
          if (owner) begin
            rdata1  <= mem_q;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= mem_q;
            rvalid0 <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin and fixed-priority instances, each with its own memory,
// checked every cycle against a transaction-timeline model plus directed literal checks.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        req    [2][2];
  logic        rw     [2][2];
  logic [15:0] addr   [2][2];
  logic [7:0]  wdata  [2][2];
  logic        gnt    [2][2];
  logic        rvalid [2][2];
  logic [7:0]  rdata  [2][2];
  logic        mem_rw   [2];
  logic [15:0] mem_addr [2];
  logic [7:0]  mem_data [2];
  logic [7:0]  mem_q    [2];
  logic [7:0]  mem      [2][65536];

  logic        bd_we;
  logic [15:0] bd_addr;
  logic [7:0]  bd_data;

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .FIXED_PRIO(g)) u_dut (
      .clk(clk), .rst(rst),
      .req0(req[g][0]), .rw0(rw[g][0]), .addr0(addr[g][0]), .wdata0(wdata[g][0]),
      .gnt0(gnt[g][0]), .rvalid0(rvalid[g][0]), .rdata0(rdata[g][0]),
      .req1(req[g][1]), .rw1(rw[g][1]), .addr1(addr[g][1]), .wdata1(wdata[g][1]),
      .gnt1(gnt[g][1]), .rvalid1(rvalid[g][1]), .rdata1(rdata[g][1]),
      .mem_rw(mem_rw[g]), .mem_addr(mem_addr[g]), .mem_data(mem_data[g]), .mem_q(mem_q[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered-read single-port memories, with a backdoor for preloading
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_rw[k]) mem[k][mem_addr[k]] <= mem_data[k];
      if (bd_we) mem[k][bd_addr] <= bd_data;
      mem_q[k] <= mem[k][mem_addr[k]];
    end
  end

  // Reference model: an access granted at edge n occupies the memory until edge n+2 (write)
  // or n+3 (read); writes land at n+1, read data is returned at n+2.
  logic [7:0]  shadow [2][65536];
  logic        x_gnt    [2][2] = '{'{1'b0, 1'b0}, '{1'b0, 1'b0}};
  logic        x_rvalid [2][2] = '{'{1'b0, 1'b0}, '{1'b0, 1'b0}};
  logic [7:0]  x_rdata  [2][2] = '{'{8'h0, 8'h0}, '{8'h0, 8'h0}};
  logic        x_mem_rw   [2] = '{1'b0, 1'b0};
  logic [15:0] x_mem_addr [2] = '{16'h0, 16'h0};
  logic [7:0]  x_mem_data [2] = '{8'h0, 8'h0};
  logic        last_g   [2] = '{1'b1, 1'b1};
  int          next_arb [2] = '{0, 0};
  int          rv_at    [2] = '{0, 0};
  int          rv_port  [2] = '{0, 0};
  logic [15:0] rv_addr  [2] = '{16'h0, 16'h0};
  int          cyc = 0;
  bit          started = 1'b0;

  task automatic model_step();
    logic w;
    cyc++;
    if (rst) started = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (x_mem_rw[k]) shadow[k][x_mem_addr[k]] = x_mem_data[k];
      if (bd_we) shadow[k][bd_addr] = bd_data;
      for (int p = 0; p < 2; p++) begin
        x_gnt[k][p]    = 1'b0;
        x_rvalid[k][p] = 1'b0;
      end
      x_mem_rw[k] = 1'b0;
      if (rst) begin
        last_g[k]     = 1'b1;
        next_arb[k]   = cyc + 1;
        rv_at[k]      = 0;
        x_mem_addr[k] = 16'h0;
        x_mem_data[k] = 8'h0;
        x_rdata[k][0] = 8'h0;
        x_rdata[k][1] = 8'h0;
      end else begin
        if (rv_at[k] == cyc) begin
          x_rvalid[k][rv_port[k]] = 1'b1;
          x_rdata[k][rv_port[k]]  = shadow[k][rv_addr[k]];
        end
        if (cyc >= next_arb[k] && (req[k][0] || req[k][1])) begin
          if (req[k][0] && req[k][1]) w = (k == 1) ? 1'b0 : ~last_g[k];
          else w = req[k][1];
          x_gnt[k][w]   = 1'b1;
          last_g[k]     = w;
          x_mem_rw[k]   = rw[k][w];
          x_mem_addr[k] = addr[k][w];
          x_mem_data[k] = wdata[k][w];
          if (rw[k][w]) begin
            next_arb[k] = cyc + 2;
          end else begin
            next_arb[k] = cyc + 3;
            rv_at[k]    = cyc + 2;
            rv_port[k]  = int'(w);
            rv_addr[k]  = addr[k][w];
          end
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h, want %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model on each falling edge
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk("gnt0", k, 32'(gnt[k][0]), 32'(x_gnt[k][0]));
        chk("gnt1", k, 32'(gnt[k][1]), 32'(x_gnt[k][1]));
        chk("rvalid0", k, 32'(rvalid[k][0]), 32'(x_rvalid[k][0]));
        chk("rvalid1", k, 32'(rvalid[k][1]), 32'(x_rvalid[k][1]));
        chk("rdata0", k, 32'(rdata[k][0]), 32'(x_rdata[k][0]));
        chk("rdata1", k, 32'(rdata[k][1]), 32'(x_rdata[k][1]));
        chk("mem_rw", k, 32'(mem_rw[k]), 32'(x_mem_rw[k]));
        chk("mem_addr", k, 32'(mem_addr[k]), 32'(x_mem_addr[k]));
        chk("mem_data", k, 32'(mem_data[k]), 32'(x_mem_data[k]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input int p, input logic r, input logic [15:0] a,
                         input logic [7:0] d);
    req[k][p]   = 1'b1;
    rw[k][p]    = r;
    addr[k][p]  = a;
    wdata[k][p] = d;
  endtask

  task automatic rand_req(input int k, input int p);
    set_req(k, p, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 8'($urandom));
  endtask

  int gp[$];
  int gt[$];
  int n_g0;
  int n_g1;

  initial begin
    rst = 1'b1;
    bd_we = 1'b0;
    bd_addr = 16'h0;
    bd_data = 8'h0;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        req[k][p] = 1'b0; rw[k][p] = 1'b0; addr[k][p] = 16'h0; wdata[k][p] = 8'h0;
      end
    end

    // Preload both memories while in reset
    bd_we = 1'b1;
    for (int a = 0; a < 32; a++) begin
      bd_addr = 16'(a);
      bd_data = 8'($urandom);
      tick();
    end
    bd_addr = 16'h0010; bd_data = 8'hA5; tick();
    bd_addr = 16'h00FF; bd_data = 8'h00; tick();
    bd_we = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_gnt0", k, 32'(gnt[k][0]), 32'd0);
      chk("rst_rvalid1", k, 32'(rvalid[k][1]), 32'd0);
      chk("rst_rdata0", k, 32'(rdata[k][0]), 32'd0);
      chk("rst_mem_addr", k, 32'(mem_addr[k]), 32'd0);
      chk("rst_mem_rw", k, 32'(mem_rw[k]), 32'd0);
    end

    // Port 0 read of a preloaded byte
    rst = 1'b0;
    set_req(0, 0, 1'b0, 16'h0010, 8'h00);
    tick();
    chk("rd_gnt0", 0, 32'(gnt[0][0]), 32'd1);
    chk("rd_mem_addr", 0, 32'(mem_addr[0]), 32'h10);
    chk("rd_mem_rw", 0, 32'(mem_rw[0]), 32'd0);
    req[0][0] = 1'b0;
    tick();
    chk("rd_gnt0_off", 0, 32'(gnt[0][0]), 32'd0);
    chk("rd_rvalid0_early", 0, 32'(rvalid[0][0]), 32'd0);
    tick();
    chk("rd_rvalid0", 0, 32'(rvalid[0][0]), 32'd1);
    chk("rd_rdata0", 0, 32'(rdata[0][0]), 32'hA5);
    chk("rd_rvalid1", 0, 32'(rvalid[0][1]), 32'd0);

    // Port 1 write then readback
    set_req(0, 1, 1'b1, 16'h00FF, 8'h3C);
    tick();
    chk("wr_gnt1", 0, 32'(gnt[0][1]), 32'd1);
    chk("wr_mem_rw", 0, 32'(mem_rw[0]), 32'd1);
    chk("wr_mem_data", 0, 32'(mem_data[0]), 32'h3C);
    req[0][1] = 1'b0;
    tick();
    chk("wr_mem_rw_off", 0, 32'(mem_rw[0]), 32'd0);
    chk("wr_landed", 0, 32'(mem[0][16'h00FF]), 32'h3C);
    set_req(0, 1, 1'b0, 16'h00FF, 8'h00);
    tick();
    chk("rb_gnt1", 0, 32'(gnt[0][1]), 32'd1);
    req[0][1] = 1'b0;
    tick();
    tick();
    chk("rb_rvalid1", 0, 32'(rvalid[0][1]), 32'd1);
    chk("rb_rdata1", 0, 32'(rdata[0][1]), 32'h3C);
    chk("rb_rdata0_hold", 0, 32'(rdata[0][0]), 32'hA5);

    // Round-robin with both ports holding reads
    set_req(0, 0, 1'b0, 16'h0010, 8'h00);
    set_req(0, 1, 1'b0, 16'h00FF, 8'h00);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (gnt[0][0]) begin gp.push_back(0); gt.push_back(i); end
      if (gnt[0][1]) begin gp.push_back(1); gt.push_back(i); end
    end
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    chk("rr_count", 0, 32'(gp.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gp.size()) chk("rr_order", 0, 32'(gp[i]), 32'(i % 2));
      if (i > 0 && i < gt.size()) chk("rr_gap", 0, 32'(gt[i] - gt[i-1]), 32'd3);
    end

    // Fixed priority: port 0 starves port 1 until it lets go
    set_req(1, 0, 1'b0, 16'h0010, 8'h00);
    set_req(1, 1, 1'b0, 16'h00FF, 8'h00);
    n_g0 = 0;
    n_g1 = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (gnt[1][0]) n_g0++;
      if (gnt[1][1]) n_g1++;
    end
    chk("fp_gnt0_count", 1, 32'(n_g0), 32'd3);
    chk("fp_gnt1_count", 1, 32'(n_g1), 32'd0);
    req[1][0] = 1'b0;
    tick();
    chk("fp_gnt1_after_drop", 1, 32'(gnt[1][1]), 32'd1);
    req[1][1] = 1'b0;
    tick();
    tick();

    // Reset during RETURN of a port 0 read drops the data
    set_req(0, 0, 1'b0, 16'h0010, 8'h00);
    tick();
    chk("rr_rst_gnt0", 0, 32'(gnt[0][0]), 32'd1);
    req[0][0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rret_rvalid0", 0, 32'(rvalid[0][0]), 32'd0);
    chk("rret_rdata0", 0, 32'(rdata[0][0]), 32'd0);
    chk("rret_mem_addr", 0, 32'(mem_addr[0]), 32'd0);
    rst = 1'b0;
    set_req(0, 0, 1'b0, 16'h0010, 8'h00);
    tick();
    chk("post_rst_gnt0", 0, 32'(gnt[0][0]), 32'd1);
    req[0][0] = 1'b0;
    tick();
    tick();
    chk("post_rst_rvalid0", 0, 32'(rvalid[0][0]), 32'd1);
    chk("post_rst_rdata0", 0, 32'(rdata[0][0]), 32'hA5);

    // Reset on the BUSY edge of a write: the byte still lands
    set_req(0, 0, 1'b1, 16'h0020, 8'h5A);
    tick();
    chk("wrst_gnt0", 0, 32'(gnt[0][0]), 32'd1);
    chk("wrst_mem_rw", 0, 32'(mem_rw[0]), 32'd1);
    rst = 1'b1;
    tick();
    chk("wrst_landed", 0, 32'(mem[0][16'h0020]), 32'h5A);
    chk("wrst_mem_rw_off", 0, 32'(mem_rw[0]), 32'd0);
    tick();
    chk("wrst_gnt0_held", 0, 32'(gnt[0][0]), 32'd0);
    chk("wrst_rvalid0", 0, 32'(rvalid[0][0]), 32'd0);
    rst = 1'b0;
    req[0][0] = 1'b0;
    tick();
    tick();

    // Randomised traffic on both instances with occasional resets
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 2; p++) begin
          if (req[k][p]) begin
            if (gnt[k][p]) begin
              if ($urandom_range(0, 2) == 0) req[k][p] = 1'b0;
              else rand_req(k, p);
            end else if ($urandom_range(0, 15) == 0) begin
              req[k][p] = 1'b0;
            end
          end else if ($urandom_range(0, 2) == 0) begin
            rand_req(k, p);
          end
        end
      end
      tick();
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req[k][0] = 1'b0;
      req[k][1] = 1'b0;
    end
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
